pipe_ctrl: RTL and testbench

Central pipeline sequencer for the 32-bit RISC-V core. Merges stall/redirect requests from the hazard unit, branch resolution in EX, data-memory wait and traps. Drives per-stage enables, flushes and the PC source select. Keeps a flush FSM that covers instruction-memory latency, plus saturating stall/flush performance counters.

---
 rtl/pipe_ctrl_if.sv | 33 +++
 rtl/pipe_ctrl.sv | 130 +++++++++++++
 tb/tb_pipe_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline sequencer and the stages it steers.
// The master side raises requests; the slave side (pipe_ctrl) returns controls and counters.
interface pipe_ctrl_if #(
    parameter int unsigned CNT_W = 32
) ();
    logic             hz_stop_i;
    logic             br_taken_i;
    logic             mem_busy_i;
    logic             trap_i;
    logic             pc_we_o;
    logic [1:0]       pc_sel_o;
    logic             if_en_o;
    logic             id_en_o;
    logic             ex_en_o;
    logic             id_flush_o;
    logic             ex_flush_o;
    logic [1:0]       state_o;
    logic             stall_err_o;
    logic [CNT_W-1:0] stall_cycles_o;
    logic [CNT_W-1:0] flush_cycles_o;

    modport master (
        output hz_stop_i, br_taken_i, mem_busy_i, trap_i,
        input  pc_we_o, pc_sel_o, if_en_o, id_en_o, ex_en_o, id_flush_o, ex_flush_o,
        input  state_o, stall_err_o, stall_cycles_o, flush_cycles_o
    );

    modport slave (
        input  hz_stop_i, br_taken_i, mem_busy_i, trap_i,
        output pc_we_o, pc_sel_o, if_en_o, id_en_o, ex_en_o, id_flush_o, ex_flush_o,
        output state_o, stall_err_o, stall_cycles_o, flush_cycles_o
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: prioritises trap/memory-wait/branch/flush/hazard requests into stage
// enables, flushes and PC select, with a redirect-flush FSM and saturating perf counters.
module pipe_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned STALL_MAX    = 7,
    parameter int unsigned CNT_W        = 32
) (
    input  logic       clk,
    input  logic       rst,
    pipe_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StHzStall = 2'd1,
        StMemWait = 2'd2,
        StFlush   = 2'd3
    } state_e;

    localparam logic [1:0] PcPlus4  = 2'd0;
    localparam logic [1:0] PcBranch = 2'd1;
    localparam logic [1:0] PcTrap   = 2'd2;

    localparam logic [2:0] FcntInit = 3'(FLUSH_CYCLES - 1);
    localparam logic [7:0] StallMax = 8'(STALL_MAX);

    state_e           state_q, state_d;
    logic [2:0]       fcnt_q, fcnt_d;
    logic [7:0]       run_q, run_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    logic       pc_we, if_en, id_en, ex_en, id_flush, ex_flush, stall_req, in_flush;
    logic [1:0] pc_sel;

    // A memory wait that interrupted a flush resumes it once busy drops.
    assign in_flush = (state_q == StFlush) || ((state_q == StMemWait) && (fcnt_q != 3'd0));

    always_comb begin
        state_d   = state_q;
        fcnt_d    = fcnt_q;
        pc_we     = 1'b1;
        pc_sel    = PcPlus4;
        if_en     = 1'b1;
        id_en     = 1'b1;
        ex_en     = 1'b1;
        id_flush  = 1'b0;
        ex_flush  = 1'b0;
        stall_req = 1'b0;

        if (bus.trap_i || (!bus.mem_busy_i && bus.br_taken_i)) begin
            pc_sel   = bus.trap_i ? PcTrap : PcBranch;
            id_flush = 1'b1;
            ex_flush = 1'b1;
            fcnt_d   = FcntInit;
            state_d  = (FcntInit == 3'd0) ? StRun : StFlush;
        end else if (bus.mem_busy_i) begin
            pc_we   = 1'b0;
            if_en   = 1'b0;
            id_en   = 1'b0;
            ex_en   = 1'b0;
            state_d = StMemWait;
        end else if (in_flush) begin
            id_flush = 1'b1;
            fcnt_d   = fcnt_q - 3'd1;
            state_d  = (fcnt_q == 3'd1) ? StRun : StFlush;
        end else if (bus.hz_stop_i) begin
            pc_we     = 1'b0;
            if_en     = 1'b0;
            id_en     = 1'b0;
            ex_flush  = 1'b1;
            stall_req = 1'b1;
            state_d   = StHzStall;
        end else begin
            state_d = StRun;
        end

        // Reset forces safe controls combinationally, independent of the clock.
        if (rst) begin
            pc_we    = 1'b0;
            pc_sel   = PcPlus4;
            if_en    = 1'b0;
            id_en    = 1'b0;
            ex_en    = 1'b0;
            id_flush = 1'b1;
            ex_flush = 1'b1;
        end
    end

    always_comb begin
        run_d = 8'd0;
        if (stall_req) begin
            run_d = (run_q == 8'hff) ? run_q : run_q + 8'd1;
        end
        err_d = err_q || (run_d >= StallMax);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StRun;
            fcnt_q      <= 3'd0;
            run_q       <= 8'd0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            run_q   <= run_d;
            err_q   <= err_d;
            if (!pc_we && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (id_flush && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.pc_we_o        = pc_we;
    assign bus.pc_sel_o       = pc_sel;
    assign bus.if_en_o        = if_en;
    assign bus.id_en_o        = id_en;
    assign bus.ex_en_o        = ex_en;
    assign bus.id_flush_o     = id_flush;
    assign bus.ex_flush_o     = ex_flush;
    assign bus.state_o        = state_q;
    assign bus.stall_err_o    = err_q;
    assign bus.stall_cycles_o = stall_cnt_q;
    assign bus.flush_cycles_o = flush_cnt_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: three parameterisations driven in lockstep by directed then random
// requests, each compared every cycle against a rule-level reference model.
module tb_pipe_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic hz = 1'b0, br = 1'b0, mb = 1'b0, tr = 1'b0;

    always #5 clk = ~clk;

    pipe_ctrl_if #(.CNT_W(32)) b0 ();
    pipe_ctrl_if #(.CNT_W(3))  b1 ();
    pipe_ctrl_if #(.CNT_W(4))  b2 ();

    assign {b0.hz_stop_i, b0.br_taken_i, b0.mem_busy_i, b0.trap_i} = {hz, br, mb, tr};
    assign {b1.hz_stop_i, b1.br_taken_i, b1.mem_busy_i, b1.trap_i} = {hz, br, mb, tr};
    assign {b2.hz_stop_i, b2.br_taken_i, b2.mem_busy_i, b2.trap_i} = {hz, br, mb, tr};

    pipe_ctrl #(.FLUSH_CYCLES(2), .STALL_MAX(4), .CNT_W(32)) u0 (.clk(clk), .rst(rst), .bus(b0));
    pipe_ctrl #(.FLUSH_CYCLES(1), .STALL_MAX(1), .CNT_W(3))  u1 (.clk(clk), .rst(rst), .bus(b1));
    pipe_ctrl #(.FLUSH_CYCLES(7), .STALL_MAX(3), .CNT_W(4))  u2 (.clk(clk), .rst(rst), .bus(b2));

    int fc[3] = '{2, 1, 7};
    int sm[3] = '{4, 1, 3};
    int cw[3] = '{32, 3, 4};

    // Reference state: remaining flush cycles, reported mode, consecutive stalls, counters.
    int              fl[3], st[3], run[3];
    bit              err[3];
    longint unsigned sc[3], fcc[3];

    int checks = 0, errors = 0, cyc = 0;

    // 1 trap, 2 mem wait, 3 branch, 4 ongoing flush, 5 hazard stall, 6 plain run.
    function automatic int rule_of(int k);
        if (tr) return 1;
        if (mb) return 2;
        if (br) return 3;
        if (fl[k] > 0) return 4;
        if (hz) return 5;
        return 6;
    endfunction

    // Expected {pc_we, pc_sel[1:0], if_en, id_en, ex_en, id_flush, ex_flush}.
    function automatic logic [7:0] ctrl_of(int k);
        if (rst) return 8'b0_00_000_11;
        case (rule_of(k))
            1:       return 8'b1_10_111_11;
            2:       return 8'b0_00_000_00;
            3:       return 8'b1_01_111_11;
            4:       return 8'b1_00_111_10;
            5:       return 8'b0_00_001_01;
            default: return 8'b1_00_111_00;
        endcase
    endfunction

    task automatic chk(input string tag, input int k, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s inst%0d cycle %0d: observed %0h expected %0h", tag, k, cyc, obs, exp);
        end
    endtask

    task automatic check_inst(input int k, input logic [7:0] ctrl, input logic [1:0] s,
                              input logic e, input logic [63:0] scn, input logic [63:0] fcn);
        chk("ctrl", k, 64'(ctrl), 64'(ctrl_of(k)));
        chk("state", k, 64'(s), rst ? 64'd0 : 64'(st[k]));
        chk("stall_err", k, 64'(e), rst ? 64'd0 : 64'(err[k]));
        chk("stall_cycles", k, scn, rst ? 64'd0 : sc[k]);
        chk("flush_cycles", k, fcn, rst ? 64'd0 : fcc[k]);
    endtask

    task automatic check_all();
        check_inst(0, {b0.pc_we_o, b0.pc_sel_o, b0.if_en_o, b0.id_en_o, b0.ex_en_o,
                       b0.id_flush_o, b0.ex_flush_o}, b0.state_o, b0.stall_err_o,
                   64'(b0.stall_cycles_o), 64'(b0.flush_cycles_o));
        check_inst(1, {b1.pc_we_o, b1.pc_sel_o, b1.if_en_o, b1.id_en_o, b1.ex_en_o,
                       b1.id_flush_o, b1.ex_flush_o}, b1.state_o, b1.stall_err_o,
                   64'(b1.stall_cycles_o), 64'(b1.flush_cycles_o));
        check_inst(2, {b2.pc_we_o, b2.pc_sel_o, b2.if_en_o, b2.id_en_o, b2.ex_en_o,
                       b2.id_flush_o, b2.ex_flush_o}, b2.state_o, b2.stall_err_o,
                   64'(b2.stall_cycles_o), 64'(b2.flush_cycles_o));
    endtask

    task automatic step(input int k);
        longint unsigned mx;
        logic [7:0]      c;
        int              r;
        mx = (64'd1 << cw[k]) - 64'd1;
        if (rst) begin
            fl[k] = 0; st[k] = 0; run[k] = 0; err[k] = 1'b0; sc[k] = 0; fcc[k] = 0;
            return;
        end
        r = rule_of(k);
        c = ctrl_of(k);
        if (!c[7] && sc[k] < mx) sc[k]++;
        if (c[1] && fcc[k] < mx) fcc[k]++;
        case (r)
            1, 3: begin fl[k] = fc[k] - 1; st[k] = (fl[k] > 0) ? 3 : 0; end
            2:    st[k] = 2;
            4:    begin fl[k]--; st[k] = (fl[k] > 0) ? 3 : 0; end
            5:    st[k] = 1;
            default: st[k] = 0;
        endcase
        run[k] = (r == 5) ? ((run[k] < 255) ? run[k] + 1 : 255) : 0;
        if (run[k] >= sm[k]) err[k] = 1'b1;
    endtask

    // Drive one cycle's inputs away from the edge, check, then advance across the edge.
    task automatic cycle(input bit r, input bit h, input bit b, input bit m, input bit t);
        rst = r; hz = h; br = b; mb = m; tr = t;
        #2;
        check_all();
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) step(k);
        cyc++;
    endtask

    initial begin
        #1 rst = 1'b1;
        #2 check_all();
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) step(k);
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);                  // first cycle after release
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 0);                  // branch redirect
        repeat (2) cycle(0, 0, 0, 0, 0);
        repeat (3) cycle(0, 1, 0, 0, 0);       // short hazard stall
        cycle(0, 0, 0, 0, 0);
        repeat (5) cycle(0, 1, 0, 0, 0);       // long hazard stall sets the sticky flag
        repeat (2) cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 0);                  // branch, then memory wait inside the flush
        repeat (2) cycle(0, 0, 0, 1, 0);
        repeat (3) cycle(0, 0, 0, 0, 0);
        cycle(0, 1, 1, 1, 1);                  // everything at once: trap wins
        repeat (3) cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 1, 0, 0);                  // branch during flush reloads it
        cycle(1, 0, 0, 0, 0);                  // reset mid-flush
        cycle(0, 0, 0, 0, 0);
        repeat (2) cycle(0, 1, 0, 0, 0);
        cycle(1, 1, 0, 0, 0);                  // reset mid-stall
        cycle(0, 0, 0, 0, 0);
        repeat (1500) begin
            cycle($urandom_range(0, 199) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 15) == 0);
        end
        repeat (40) cycle(0, 0, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
